alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one 32-bit ALU_32 instance among NUM_REQ requesters (e.g. issue slots, AGU, branch unit).
//  Round-robin grant; valid/ready handshake on request and response sides; 2-stage pipeline.
//  Stage 1: operand register. Stage 2: result register.
//  Routes each result back to the requester that issued it, and flags illegal opcodes.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..8
//  PTR_W     $clog2(NUM_REQ)   derived localparam; grant-index width
// PORTS
//  clk         in   1            rising-edge clock, the only clock
//  rst         in   1            asynchronous, active-high reset
//  req_valid   in   NUM_REQ      per-requester request valid
//  req_ready   out  NUM_REQ      one-hot accept; at most one bit set per cycle
//  req_op      in   NUM_REQ*4    alu_op per requester; slice i = [4*i+3:4*i]
//  req_a       in   NUM_REQ*32   operand_a per requester; slice i = [32*i+31:32*i]
//  req_b       in   NUM_REQ*32   operand_b per requester; same slicing as req_a
//  rsp_valid   out  NUM_REQ      one-hot response valid to the originating requester
//  rsp_ready   in   NUM_REQ      per-requester response accept
//  rsp_result  out  32           shared result bus; meaningful only where rsp_valid is set
//  rsp_err     out  1            opcode was not a defined ALU op; qualified by |rsp_valid
//  busy        out  1            either pipeline stage holds a valid entry
// BEHAVIOUR
//  Reset (async assert, sync deassert upstream): s1_vld=0, s2_vld=0, rr_ptr=0.
//   req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0.
//  Stall rule: s2_stall = s2_vld & ~rsp_ready[s2_id]; s1_stall = s1_vld & s2_stall.
//  Grant: when ~s1_stall, search req_valid from rr_ptr upward with wrap-around.
//   The first set bit is the grantee g, and req_ready[g]=1 combinationally.
//   req_ready is never asserted while s1_stall.
//  Accept (req_valid[g] & req_ready[g]): s1 <= {op,a,b,id=g}, s1_vld<=1, rr_ptr <= (g+1) mod NUM_REQ.
//  No request and ~s1_stall: s1_vld<=0 and rr_ptr holds.
//  ALU_32 is driven combinationally from s1 operands.
//   s1_err = op not one of ADD/SUB/SLL/XOR/SRL/SRA/OR/AND.
//  s1->s2 when s1_vld & ~s2_stall: s2_result <= s1_err ? 0 : alu_result.
//   s2_err<=s1_err, s2_id<=s1.id, s2_vld<=1.
//   ~s1_vld & ~s2_stall: s2_vld<=0.
//  Illegal opcodes never propagate X: result is forced to 32'h0 and rsp_err=1.
//  rsp_valid = s2_vld ? (1<<s2_id) : 0. rsp_result/rsp_err come from s2 and are 0 when ~s2_vld.
//  Latency: accepted at edge N -> rsp_valid at edge N+2 (visible after). Throughput 1/cycle with no stall.
//  Backpressure: while s2_stall, s2 contents are held stable; s1 holds if valid.
//   A bubble in s1 may still be filled (s1 not valid -> not stalled).
//  Simultaneous s2 drain and new accept in the same cycle is legal; full throughput.
//  Requester holding req_valid with changing operands before accept: the value at the accept edge is used.
//  Single requester streaming: it is granted every cycle; the rr_ptr rotation does not starve it.
//  Fairness: any continuously valid requester is accepted within NUM_REQ accepts.
//  Reset mid-operation: in-flight entries are dropped, no response is issued, rr_ptr returns to 0.
//  rsp_ready on a non-selected requester is ignored.
// STRUCTURE
//  Package types: alu_op_t / ALU_* opcode constants (existing).
//   Add function is_legal_alu_op(alu_op_t) so it is shared with decode.
//  Sub-module: one ALU_32 instance (u_alu), unmodified.
//  Round-robin pick is a local function (rotate, priority-encode, un-rotate); no extra module.
// TESTING
//  1 Reset: assert rst mid-stream -> all outputs 0 that cycle (async); after release, first grant goes to req 0.
//  2 Single op: req1 ADD a=5 b=7 -> req_ready[1] at cycle 0; rsp_valid=4'b0010, result=12 two edges later.
//  3 Round robin: all 4 valid continuously -> grant order 0,1,2,3,0.
//   SUB 10-3 on req2 returns 7 to rsp_valid[2] only.
//  4 Backpressure: rsp_ready[0]=0 for 3 cycles with ops queued -> s2 result stable.
//   After one more accept, req_ready=0; no loss/dup; in-order release when ready rises.
//  5 Illegal op 4'hF on req3 -> rsp_valid[3]=1, rsp_err=1, rsp_result=0 (no X).
//   The next legal op has rsp_err=0.
//  6 Shift/sign: SRA a=32'h8000_0000 b=32'h24 -> result 32'hF800_0000 (b[4:0]=4).
//   SLL by 31 -> bit31 only.

Source files
------------

// File: rtl/alu_rr_arbiter_pkg.sv
// rtl/alu_rr_arbiter_pkg.sv - ALU opcode type, opcode constants and legality check
package alu_rr_arbiter_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 4'b0000;
    localparam alu_op_t ALU_SLL = 4'b0001;
    localparam alu_op_t ALU_XOR = 4'b0100;
    localparam alu_op_t ALU_SRL = 4'b0101;
    localparam alu_op_t ALU_OR  = 4'b0110;
    localparam alu_op_t ALU_AND = 4'b0111;
    localparam alu_op_t ALU_SUB = 4'b1000;
    localparam alu_op_t ALU_SRA = 4'b1101;

    // Shared with decode so both agree on which encodings are real ALU ops.
    function automatic logic is_legal_alu_op(input alu_op_t op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_XOR,
            ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_32.sv
// rtl/alu_32.sv - 32-bit combinational ALU
module alu_32
    import alu_rr_arbiter_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    // Undefined opcodes yield zero so nothing downstream ever sees X.
    always_comb begin
        result = 32'h0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SRA: result = $unsigned($signed(a) >>> shamt);
            ALU_XOR: result = a ^ b;
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin sharing of one ALU among NUM_REQ requesters
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*4-1:0]  req_op,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int PTR_W1 = PTR_W + 1;

    logic             s1_vld;
    alu_op_t          s1_op;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [PTR_W-1:0] s1_id;
    logic             s1_err;

    logic             s2_vld;
    logic [31:0]      s2_result;
    logic             s2_err;
    logic [PTR_W-1:0] s2_id;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W1-1:0] pick;
    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_ok;
    logic [PTR_W-1:0]  next_ptr;
    logic              s2_stall;
    logic              s1_stall;
    logic [31:0]       alu_result;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    // Returns {found, index}.
    function automatic logic [PTR_W1-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                  input logic [PTR_W-1:0]   ptr);
        logic [NUM_REQ-1:0] rot;
        logic               found;
        logic [PTR_W-1:0]   k;
        logic [PTR_W1-1:0]  sum;
        rot   = NUM_REQ'({vld, vld} >> ptr);
        found = 1'b0;
        k     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                k     = PTR_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, k};
        if (sum >= PTR_W1'(NUM_REQ)) begin
            sum = sum - PTR_W1'(NUM_REQ);
        end
        return {found, sum[PTR_W-1:0]};
    endfunction

    alu_32 u_alu (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .result (alu_result)
    );

    // Stall chain, grant selection and the one-hot accept vector.
    always_comb begin
        pick        = rr_pick(req_valid, rr_ptr);
        grant_found = pick[PTR_W];
        grant_idx   = pick[PTR_W-1:0];
        s2_stall    = s2_vld & ~rsp_ready[s2_id];
        s1_stall    = s1_vld & s2_stall;
        grant_ok    = grant_found & ~s1_stall & ~rst;
        next_ptr    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        s1_err      = ~is_legal_alu_op(s1_op);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_ok & (grant_idx == PTR_W'(i));
        end
    end

    // Response side is driven only from stage 2 and is all-zero when it is empty.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = s2_vld & (s2_id == PTR_W'(i));
        end
        rsp_result = s2_vld ? s2_result : 32'h0;
        rsp_err    = s2_vld & s2_err;
        busy       = s1_vld | s2_vld;
    end

    // Two-stage pipeline plus rotating priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_op     <= ALU_ADD;
            s1_a      <= 32'h0;
            s1_b      <= 32'h0;
            s1_id     <= '0;
            s2_vld    <= 1'b0;
            s2_result <= 32'h0;
            s2_err    <= 1'b0;
            s2_id     <= '0;
            rr_ptr    <= '0;
        end else begin
            if (!s1_stall) begin
                if (grant_ok) begin
                    s1_vld <= 1'b1;
                    s1_op  <= req_op[{grant_idx, 2'b00} +: 4];
                    s1_a   <= req_a[{grant_idx, 5'b00000} +: 32];
                    s1_b   <= req_b[{grant_idx, 5'b00000} +: 32];
                    s1_id  <= grant_idx;
                    rr_ptr <= next_ptr;
                end else begin
                    s1_vld <= 1'b0;
                end
            end
            if (!s2_stall) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_result <= s1_err ? 32'h0 : alu_result;
                    s2_err    <= s1_err;
                    s2_id     <= s1_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - self-checking bench for alu_rr_arbiter
module tb_alu_rr_arbiter;
    import alu_rr_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [15:0]  req_op = '0;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready = '0;
    logic [31:0]  rsp_result;
    logic         rsp_err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ptr = 0;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        err;
        int          acc;
    } ent_t;

    ent_t q[$];

    logic [3:0]  seen_ready;
    logic [3:0]  seen_rsp_valid;
    logic [31:0] seen_rsp_result;
    logic [31:0] hold_result;
    logic [3:0]  legal_ops [8] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_XOR,
                                   ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND};

    alu_rr_arbiter #(.NUM_REQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: {illegal, result}
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        logic signed [31:0] sa;
        sh = b % 32;
        sa = a;
        case (op)
            ALU_ADD: return {1'b0, a + b};
            ALU_SUB: return {1'b0, a - b};
            ALU_SLL: return {1'b0, a << sh};
            ALU_SRL: return {1'b0, a >> sh};
            ALU_SRA: return {1'b0, 32'(sa >>> sh)};
            ALU_XOR: return {1'b0, a ^ b};
            ALU_OR:  return {1'b0, a | b};
            ALU_AND: return {1'b0, a & b};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[4*i +: 4]   = op;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        req_valid[i]       = 1'b1;
    endtask

    // One clock: check every output against the model at the falling edge, then advance the model.
    task automatic cycle();
        int          g;
        bit          out;
        bit          stall;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_vld;
        logic [31:0] exp_res;
        logic        exp_err;
        logic [32:0] r;
        ent_t        e;
        @(negedge clk);
        out   = (q.size() > 0) && (cyc >= q[0].acc + 2);
        stall = (q.size() == 2) && !rsp_ready[q[0].id];
        g = -1;
        if (!stall) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && req_valid[(ptr + k) % 4]) g = (ptr + k) % 4;
            end
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'h0;
        exp_vld   = out ? 4'(1 << q[0].id) : 4'h0;
        exp_res   = out ? q[0].res : 32'h0;
        exp_err   = out ? q[0].err : 1'b0;
        seen_ready      = req_ready;
        seen_rsp_valid  = rsp_valid;
        seen_rsp_result = rsp_result;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (out && rsp_ready[q[0].id]) void'(q.pop_front());
        if (g >= 0) begin
            r     = ref_alu(req_op[4*g +: 4], req_a[32*g +: 32], req_b[32*g +: 32]);
            e.id  = g;
            e.res = r[31:0];
            e.err = r[32];
            e.acc = cyc;
            q.push_back(e);
            ptr = (g + 1) % 4;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_result"}, rsp_result, 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int exp_rr [5] = '{0, 1, 2, 3, 0};

        // Reset state: outputs quiet even with every request raised.
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        set_req(1, ALU_XOR, 32'hFF, 32'h0F);
        rsp_ready = 4'hF;
        cycle();
        cycle();

        // Asynchronous reset mid-stream drops in-flight work immediately.
        #2;
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        ptr = 0;

        // Round robin with all four requesters continuously valid.
        for (int i = 0; i < 4; i++) set_req(i, ALU_ADD, $urandom, $urandom);
        set_req(2, ALU_SUB, 32'd10, 32'd3);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_grant", 32'(seen_ready), 32'(1 << exp_rr[i]));
        end
        chk("sub_rsp_valid", 32'(seen_rsp_valid), 32'h4);
        chk("sub_result", seen_rsp_result, 32'd7);
        req_valid = '0;
        repeat (3) cycle();

        // Single ADD on requester 1.
        set_req(1, ALU_ADD, 32'd5, 32'd7);
        cycle();
        chk("add_grant", 32'(seen_ready), 32'h2);
        req_valid = '0;
        cycle();
        chk("add_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("add_result", rsp_result, 32'd12);
        cycle();

        // Backpressure on requester 0.
        rsp_ready = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            set_req(0, ALU_ADD, $urandom, $urandom);
            cycle();
            if (i == 2) begin
                hold_result = seen_rsp_result;
                chk("bp_rsp_valid", 32'(seen_rsp_valid), 32'h1);
            end
            if (i >= 2) begin
                chk("bp_ready_low", 32'(seen_ready), 32'h0);
                chk("bp_hold", seen_rsp_result, hold_result);
            end
        end
        rsp_ready = 4'hF;
        req_valid = '0;
        repeat (4) cycle();

        // Illegal opcode then a legal one on requester 3.
        set_req(3, 4'hF, $urandom, $urandom);
        cycle();
        set_req(3, ALU_ADD, 32'd1, 32'd2);
        cycle();
        req_valid = '0;
        chk("ill_rsp_valid", 32'(rsp_valid), 32'h8);
        chk("ill_err", 32'(rsp_err), 32'h1);
        chk("ill_result", rsp_result, 32'h0);
        cycle();
        chk("post_ill_err", 32'(rsp_err), 32'h0);
        chk("post_ill_result", rsp_result, 32'd3);
        cycle();

        // Shift edge cases.
        set_req(0, ALU_SRA, 32'h8000_0000, 32'h24);
        cycle();
        set_req(0, ALU_SLL, 32'hFFFF_FFFF, 32'd31);
        cycle();
        req_valid = '0;
        chk("sra_result", rsp_result, 32'hF800_0000);
        cycle();
        chk("sll_result", rsp_result, 32'h8000_0000);
        cycle();

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                req_op[4*i +: 4]  = ($urandom_range(0, 9) == 0) ? 4'($urandom)
                                                                 : legal_ops[$urandom_range(0, 7)];
                req_a[32*i +: 32] = $urandom;
                req_b[32*i +: 32] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40))
                                                                 : $urandom;
                rsp_ready[i]      = ($urandom_range(0, 3) != 0);
            end
            req_valid = 4'($urandom);
            cycle();
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
